simon_control_1: RTL and testbench

Iterative SIMON 32/64 block-cipher core built around its control FSM. It starts on its own after reset release and runs three phases: load the four key words, expand them into a 32-entry round-key schedule, then run 32 encryption or decryption rounds on a loaded block. Phase strobes and the round index are exported so the surrounding design and benches can track progress.

---
 rtl/simon_pkg.sv | 34 +++
 rtl/simon_control_1_if.sv | 26 ++
 rtl/simon_round_f.sv | 11 +
 rtl/simon_control_1.sv | 141 ++++++++++++++
 tb/tb_simon_control_1.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared parameters, state encoding and bit-rotation helpers for the
// iterative SIMON 32/64 core.
package simon_pkg;

  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 32;

  // z0 sequence; the leftmost character is bit 0 of the sequence.
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  typedef enum logic [2:0] {
    S_KLD   = 3'd0,
    S_KEXP  = 3'd1,
    S_PLD   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int unsigned s);
    rol = (a << s) | (a >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] a, input int unsigned s);
    ror = (a >> s) | (a << (N - s));
  endfunction

  function automatic logic z0_bit(input int j);
    logic [5:0] idx_s;
    idx_s  = 6'(32'sd61 - (j % 32'sd62));
    z0_bit = Z0[idx_s];
  endfunction

endpackage

// File: rtl/simon_control_1_if.sv
// Block-level bus of the SIMON core: inputs sampled in their load phases,
// result, round index and phase strobes.
interface simon_control_1_if;
  import simon_pkg::*;

  logic           enc_dec;
  logic [2*N-1:0] plain;
  logic [N-1:0]   key [M-1:0];
  logic [2*N-1:0] cipher;
  int             count;
  logic           kLd;
  logic           kExp;
  logic           pLd;
  logic           done;

  modport master (
    output enc_dec, plain, key,
    input  cipher, count, kLd, kExp, pLd, done
  );

  modport slave (
    input  enc_dec, plain, key,
    output cipher, count, kLd, kExp, pLd, done
  );

endinterface

// File: rtl/simon_round_f.sv
// SIMON round nonlinearity f(a) = (rol(a,1) & rol(a,8)) ^ rol(a,2).
module simon_round_f
  import simon_pkg::*;
(
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  assign y = (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);

endmodule

// File: rtl/simon_control_1.sv
// Iterative SIMON 32/64 core: key load, key expansion, block load, then
// 32 encrypt or decrypt rounds; parks in S_DONE until reset.
module simon_control_1
  import simon_pkg::*;
(
  input logic               clk,
  input logic               nReset,
  simon_control_1_if.slave  bus
);

  state_t         state_r;
  state_t         state_next_s;
  logic [4:0]     count_r;
  logic [N-1:0]   x_r;
  logic [N-1:0]   y_r;
  logic           enc_dec_r;
  logic [N-1:0]   ks_r [T];

  logic [N-1:0]   tmp0_s;
  logic [N-1:0]   tmp1_s;
  logic [N-1:0]   ks_new_s;
  logic           z_s;
  logic [N-1:0]   f_in_s;
  logic [N-1:0]   f_out_s;
  logic [N-1:0]   rk_s;
  logic [N-1:0]   x_next_s;
  logic [N-1:0]   y_next_s;
  logic           last_kexp_s;
  logic           last_round_s;

  // Decrypt runs f on y; a single f instance serves both directions.
  simon_round_f u_round_f (
    .a (f_in_s),
    .y (f_out_s)
  );

  assign last_kexp_s  = (count_r == 5'd31);
  assign last_round_s = enc_dec_r ? (count_r == 5'd0) : (count_r == 5'd31);
  assign rk_s         = ks_r[count_r];
  assign f_in_s       = enc_dec_r ? y_r : x_r;

  // Key-expansion XOR network for entry ks[count].
  always_comb begin
    z_s      = z0_bit({27'd0, count_r} - 32'sd4);
    tmp0_s   = ror(ks_r[count_r - 5'd1], 3) ^ ks_r[count_r - 5'd3];
    tmp1_s   = tmp0_s ^ ror(tmp0_s, 1);
    ks_new_s = ~ks_r[count_r - 5'd4] ^ tmp1_s ^ {{(N-1){1'b0}}, z_s} ^ 16'd3;
  end

  // One Feistel round in the latched direction.
  always_comb begin
    x_next_s = x_r;
    y_next_s = y_r;
    if (enc_dec_r) begin
      y_next_s = x_r ^ f_out_s ^ rk_s;
      x_next_s = y_r;
    end else begin
      x_next_s = y_r ^ f_out_s ^ rk_s;
      y_next_s = x_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_r <= S_KLD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_KLD:   state_next_s = S_KEXP;
      S_KEXP:  begin
        if (last_kexp_s) state_next_s = S_PLD;
        else             state_next_s = S_KEXP;
      end
      S_PLD:   state_next_s = S_ROUND;
      S_ROUND: begin
        if (last_round_s) state_next_s = S_DONE;
        else              state_next_s = S_ROUND;
      end
      S_DONE:  state_next_s = S_DONE;
      default: state_next_s = S_KLD;
    endcase
  end

  // Index, block and direction registers; count stays put on the final round.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      count_r   <= 5'd0;
      x_r       <= '0;
      y_r       <= '0;
      enc_dec_r <= 1'b0;
    end else begin
      case (state_r)
        S_KLD:   count_r <= 5'd4;
        S_KEXP:  count_r <= last_kexp_s ? 5'd0 : count_r + 5'd1;
        S_PLD: begin
          x_r       <= bus.plain[2*N-1:N];
          y_r       <= bus.plain[N-1:0];
          enc_dec_r <= bus.enc_dec;
          count_r   <= bus.enc_dec ? 5'd31 : 5'd0;
        end
        S_ROUND: begin
          x_r <= x_next_s;
          y_r <= y_next_s;
          if (!last_round_s) begin
            count_r <= enc_dec_r ? count_r - 5'd1 : count_r + 5'd1;
          end
        end
        S_DONE:  count_r <= count_r;
        default: count_r <= 5'd0;
      endcase
    end
  end

  // Round-key schedule: not reset, rewritten from scratch on every run.
  always_ff @(posedge clk) begin
    case (state_r)
      S_KLD: begin
        for (int i = 0; i < M; i++) begin
          ks_r[i] <= bus.key[i];
        end
      end
      S_KEXP:  ks_r[count_r] <= ks_new_s;
      default: ;
    endcase
  end

  assign bus.cipher = {x_r, y_r};
  assign bus.count  = {27'd0, count_r};
  assign bus.kLd    = (state_r == S_KLD);
  assign bus.kExp   = (state_r == S_KEXP);
  assign bus.pLd    = (state_r == S_PLD);
  assign bus.done   = (state_r == S_DONE);

endmodule

// File: tb/tb_simon_control_1.sv
// Scoreboarded bench for simon_control_1: published SIMON 32/64 vectors,
// phase timing, key schedule, mid-run reset and input stability.
module tb_simon_control_1;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  simon_control_1_if sif ();

  simon_control_1 dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (sif)
  );

  localparam logic [31:0] PT = 32'h6565_6877;
  localparam logic [31:0] CT = 32'hC69B_E9BB;
  localparam logic [61:0] Z0_REF = 62'b11111010001001010110000111001101111101000100101011000011100110;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  logic [31:0] exp_q [$];
  logic done_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] a, input int s);
    return (a >> s) | (a << (16 - s));
  endfunction

  // Monitor: on each rising done, pop the expected block and compare.
  always @(negedge clk) begin
    if (sif.done && !done_q) begin
      n_results++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL cipher: got %h with no expected value queued", sif.cipher);
      end else begin
        check("cipher", sif.cipher, exp_q.pop_front());
      end
    end
    done_q <= sif.done;
  end

  task automatic do_reset();
    @(negedge clk);
    nReset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cipher", sif.cipher, 32'h0);
    check("rst_strobes", {28'd0, sif.kLd, sif.kExp, sif.pLd, sif.done}, 32'h8);
    check("rst_count", sif.count, 32'd0);
    nReset = 1'b1;
  endtask

  // Full 62-edge run from a negedge just after reset release.
  task automatic run_full(input logic e, input logic [31:0] p, input logic [31:0] expc);
    logic [3:0] exp_strb;
    int exp_cnt;
    sif.enc_dec = e;
    sif.plain   = p;
    exp_q.push_back(expc);
    for (int c = 1; c <= 62; c++) begin
      if (c == 1) begin
        exp_strb = 4'b1000; exp_cnt = 0;
      end else if (c <= 29) begin
        exp_strb = 4'b0100; exp_cnt = c + 2;
      end else if (c == 30) begin
        exp_strb = 4'b0010; exp_cnt = 0;
      end else begin
        exp_strb = 4'b0000; exp_cnt = e ? (62 - c) : (c - 31);
      end
      check("strobes", {28'd0, sif.kLd, sif.kExp, sif.pLd, sif.done}, {28'd0, exp_strb});
      check("count", sif.count, exp_cnt);
      @(posedge clk);
      @(negedge clk);
      if (c == 30) begin
        sif.plain   = ~p;
        sif.enc_dec = ~e;
      end
    end
    check("done_strobes", {28'd0, sif.kLd, sif.kExp, sif.pLd, sif.done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ks_m [32];
    logic [15:0] tmp;
    sif.enc_dec = 1'b0;
    sif.plain   = 32'h0;
    sif.key[0]  = 16'h0100;
    sif.key[1]  = 16'h0908;
    sif.key[2]  = 16'h1110;
    sif.key[3]  = 16'h1918;

    // Encrypt the published vector; inputs are scrambled after pLd.
    do_reset();
    run_full(1'b0, PT, CT);

    // Key schedule against a software model.
    for (int i = 0; i < 4; i++) ks_m[i] = sif.key[i];
    for (int i = 4; i < 32; i++) begin
      tmp = ror16(ks_m[i-1], 3) ^ ks_m[i-3];
      tmp = tmp ^ ror16(tmp, 1);
      ks_m[i] = ~ks_m[i-4] ^ tmp ^ {15'd0, Z0_REF[61-(i-4)]} ^ 16'd3;
    end
    for (int i = 4; i < 32; i++) begin
      check($sformatf("ks[%0d]", i), {16'd0, dut.ks_r[i]}, {16'd0, ks_m[i]});
    end

    // Inputs toggling while done must not disturb the result.
    for (int k = 0; k < 3; k++) begin
      sif.plain   = 32'hA5A5_0000 + 32'(k);
      sif.enc_dec = k[0];
      @(posedge clk);
      @(negedge clk);
      check("hold_cipher", sif.cipher, CT);
      check("hold_done", {31'd0, sif.done}, 32'd1);
    end

    // Decrypt the ciphertext back; count finishes at 0.
    do_reset();
    run_full(1'b1, CT, PT);
    check("dec_count_end", sif.count, 32'd0);

    // Asynchronous reset at edge 40, then a complete rerun.
    do_reset();
    sif.enc_dec = 1'b0;
    sif.plain   = PT;
    repeat (40) @(posedge clk);
    #1 nReset = 1'b0;
    #1;
    check("abort_cipher", sif.cipher, 32'h0);
    check("abort_strobes", {28'd0, sif.kLd, sif.kExp, sif.pLd, sif.done}, 32'h8);
    check("abort_count", sif.count, 32'd0);
    @(negedge clk);
    nReset = 1'b1;
    run_full(1'b0, PT, CT);

    @(negedge clk);
    check("results_seen", n_results, 32'd3);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
